// File: rtl/memory_writeback.sv
// Memory + writeback pipeline end: data RAM with loads/stores, M->W register and result mux.
// Range errors on loads and stores raise a sticky AddrErr that only reset clears.
module memory_writeback #(
  parameter int DW    = 19,
  parameter int PCW   = 15,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           RegWriteM,
  input  logic           MemWriteM,
  input  logic [1:0]     ResultSrcM,
  input  logic [4:0]     RDM,
  input  logic [DW-1:0]  WriteDataM,
  input  logic [DW-1:0]  ALUResultM,
  input  logic [PCW-1:0] PCPlus1M,
  output logic           RegWriteW,
  output logic [4:0]     RDW,
  output logic [DW-1:0]  ResultW,
  output logic           AddrErr
);

  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

  logic [DW-1:0]  mem [DEPTH];

  logic           reg_write_d,  reg_write_q;
  logic [4:0]     rd_d,         rd_q;
  logic [1:0]     result_src_d, result_src_q;
  logic [DW-1:0]  alu_result_d, alu_result_q;
  logic [PCW-1:0] pc_plus1_d,   pc_plus1_q;
  logic [DW-1:0]  read_data_d,  read_data_q;
  logic           addr_err_d,   addr_err_q;

  logic           in_range;
  logic           is_load;
  logic           mem_we;
  logic [AW-1:0]  ram_addr;

  // Next-state for the M->W register, RAM access decode and sticky error.
  always_comb begin
    ram_addr     = ALUResultM[AW-1:0];
    in_range     = (ALUResultM < DEPTH_W);
    is_load      = (ResultSrcM == 2'b01);
    reg_write_d  = RegWriteM & (RDM != 5'd0);
    rd_d         = RDM;
    result_src_d = ResultSrcM;
    alu_result_d = ALUResultM;
    pc_plus1_d   = PCPlus1M;
    read_data_d  = '0;
    mem_we       = 1'b0;
    if (MemWriteM && in_range && !reset) begin
      mem_we = 1'b1;
    end else begin
      mem_we = 1'b0;
    end
    // Combinational read sees the pre-write word, so a same-cycle store never bypasses.
    if (is_load && in_range) begin
      read_data_d = mem[ram_addr];
    end else begin
      read_data_d = '0;
    end
    addr_err_d = addr_err_q | ((MemWriteM | is_load) & ~in_range);
  end

  // M->W pipeline register, load data capture and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      result_src_q <= 2'b00;
      alu_result_q <= '0;
      pc_plus1_q   <= '0;
      read_data_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      pc_plus1_q   <= pc_plus1_d;
      read_data_q  <= read_data_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ram_addr] <= WriteDataM;
    end
  end

  // Writeback result select; 11 aliases the ALU path.
  always_comb begin
    ResultW = alu_result_q;
    case (result_src_q)
      2'b00:   ResultW = alu_result_q;
      2'b01:   ResultW = read_data_q;
      2'b10:   ResultW = {{(DW-PCW){1'b0}}, pc_plus1_q};
      default: ResultW = alu_result_q;
    endcase
  end

  assign RegWriteW = reg_write_q;
  assign RDW       = rd_q;
  assign AddrErr   = addr_err_q;

endmodule
